subneg_mem_responder: RTL and testbench

//  Memory-side responder for the SUBNEG core's external bus. Emulates the

---
 rtl/subneg_mem_responder.sv | 120 ++++++++++++
 tb/tb_subneg_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subneg_mem_responder.sv
// Memory-side responder for the SUBNEG core bus: address latch, SRAM,
// output latch, contention flag and a program loader used while the core is held.
module subneg_mem_responder #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int OUT_ADDR = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              cpu_latch,
   input  logic              cpu_oe_n,
   input  logic              cpu_we_n,
   input  logic              cpu_out_clk,
   input  logic [DATA_W-1:0] cpu_dout,
   output logic [DATA_W-1:0] mem_dout,
   output logic              mem_doe,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic [7:0]        out_count,
   output logic              bus_err
);

   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] OUT_SEL = ADDR_W'(OUT_ADDR);

   // Program storage; deliberately not reset so a core reset keeps the program.
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              r_latch_q;
   logic              r_we_q;
   logic              r_out_q;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic [7:0]        r_out_count;
   logic              r_bus_err;

   logic w_latch_rise;
   logic w_we_fall;
   logic w_out_rise;
   logic w_contention;
   logic w_core_wr;
   logic w_load_wr;

   // Strobe edges only count while the core owns the bus; history flops
   // track regardless so that raising run never creates a phantom edge.
   assign w_latch_rise = run & cpu_latch & ~r_latch_q;
   assign w_we_fall    = run & ~cpu_we_n & r_we_q;
   assign w_out_rise   = run & cpu_out_clk & ~r_out_q;
   assign w_contention = run & ~cpu_oe_n & ~cpu_we_n;

   // A write needs oe_n high (which also suppresses writes during contention),
   // must not target the output-latch address, and is abandoned under reset.
   assign w_core_wr = w_we_fall & cpu_oe_n & (r_addr != OUT_SEL) & ~reset;

   assign load_ready = ~run & ~reset;
   assign w_load_wr  = load_valid & load_ready;

   assign mem_doe   = run & ~cpu_oe_n;
   assign mem_dout  = mem_doe ? r_mem[r_addr] : '0;
   assign dbg_data  = r_mem[dbg_addr];
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_count = r_out_count;
   assign bus_err   = r_bus_err;

   // Strobe history, forced to idle levels on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_latch_q <= 1'b0;
         r_we_q    <= 1'b1;
         r_out_q   <= 1'b0;
      end else begin
         r_latch_q <= cpu_latch;
         r_we_q    <= cpu_we_n;
         r_out_q   <= cpu_out_clk;
      end
   end

   // Address latch, output latch, capture counter and sticky contention flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_count <= 8'd0;
         r_bus_err   <= 1'b0;
      end else begin
         r_out_valid <= w_out_rise;
         if (w_latch_rise) begin
            r_addr <= cpu_dout[ADDR_W-1:0];
         end
         if (w_out_rise) begin
            r_out_data  <= cpu_dout;
            r_out_count <= r_out_count + 8'd1;
         end
         if (w_contention) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Memory writes: loader when held, core otherwise; a simultaneous latch
   // rise still writes through the old address because r_addr updates later.
   always_ff @(posedge clk) begin
      if (w_load_wr) begin
         r_mem[load_addr] <= load_data;
      end else if (w_core_wr) begin
         r_mem[r_addr] <= cpu_dout;
      end
   end

endmodule

// File: tb/tb_subneg_mem_responder.sv
// Scoreboard bench for subneg_mem_responder: stimulus pushes expected bus
// reads and output captures; monitors pop and compare when the DUT presents them.
module tb_subneg_mem_responder;

   logic       clk;
   logic       reset;
   logic       run;
   logic       cpu_latch;
   logic       cpu_oe_n;
   logic       cpu_we_n;
   logic       cpu_out_clk;
   logic [7:0] cpu_dout;
   logic [7:0] mem_dout;
   logic       mem_doe;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_addr;
   logic [7:0] load_data;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic [7:0] out_count;
   logic       bus_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] rd_q[$];
   logic [7:0] out_q[$];

   subneg_mem_responder #(.ADDR_W(8), .DATA_W(8), .OUT_ADDR(255)) dut (
      .clk(clk), .reset(reset), .run(run),
      .cpu_latch(cpu_latch), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
      .cpu_out_clk(cpu_out_clk), .cpu_dout(cpu_dout),
      .mem_dout(mem_dout), .mem_doe(mem_doe),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .out_data(out_data), .out_valid(out_valid), .out_count(out_count),
      .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Bus-read monitor: every cycle the memory drives the bus is one expected read.
   always @(negedge clk) begin
      if (mem_doe === 1'b1) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %0h expected no read", mem_dout);
         end else begin
            chk("rd_data", mem_dout, rd_q.pop_front());
         end
      end
   end

   // Output-latch monitor: every out_valid cycle is one expected capture.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %0h expected no pulse", out_data);
         end else begin
            chk("out_data", out_data, out_q.pop_front());
         end
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [7:0] a, input logic [7:0] d);
      load_addr  = a;
      load_data  = d;
      load_valid = 1'b1;
      cyc();
      load_valid = 1'b0;
   endtask

   task automatic latch_addr(input logic [7:0] a);
      cpu_dout  = a;
      cpu_latch = 1'b1;
      cyc();
      cpu_latch = 1'b0;
      cyc();
   endtask

   task automatic rd(input logic [7:0] exp);
      rd_q.push_back(exp);
      cpu_oe_n = 1'b0;
      cyc();
      cpu_oe_n = 1'b1;
   endtask

   task automatic wr(input logic [7:0] d);
      cpu_dout = d;
      cpu_we_n = 1'b0;
      cyc();
      cpu_we_n = 1'b1;
      cyc();
   endtask

   task automatic outp(input logic [7:0] d);
      out_q.push_back(d);
      cpu_dout    = d;
      cpu_out_clk = 1'b1;
      cyc();
      cpu_out_clk = 1'b0;
      cyc();
   endtask

   initial begin
      reset = 1'b1; run = 1'b0;
      cpu_latch = 1'b0; cpu_oe_n = 1'b1; cpu_we_n = 1'b1; cpu_out_clk = 1'b0;
      cpu_dout = 8'h00; load_valid = 1'b0; load_addr = 8'h00; load_data = 8'h00;
      dbg_addr = 8'h00;

      // reset state
      cyc();
      @(negedge clk);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_count", out_count, 8'h00);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_load_ready", load_ready, 1'b0);
      chk("rst_mem_doe", mem_doe, 1'b0);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("idle_load_ready", load_ready, 1'b1);

      // program preload
      ld(8'd0, 8'd10); ld(8'd1, 8'd11); ld(8'd2, 8'd3);
      ld(8'd10, 8'd5); ld(8'd11, 8'd7); ld(8'd4, 8'h00); ld(8'd255, 8'h77);

      // basic reads
      run = 1'b1;
      latch_addr(8'd0);  rd(8'd10);
      latch_addr(8'd10); rd(8'd5);
      latch_addr(8'd1);  rd(8'd11);

      // write once per falling edge
      latch_addr(8'd11);
      cpu_dout = 8'd2; cpu_we_n = 1'b0;
      cyc();
      dbg_addr = 8'd11;
      @(negedge clk);
      chk("wr_first", dbg_data, 8'd2);
      cpu_dout = 8'd9;
      repeat (3) cyc();
      @(negedge clk);
      chk("wr_held", dbg_data, 8'd2);
      cpu_we_n = 1'b1;
      cyc();
      rd(8'd2);

      // output latch, one pulse for a held strobe
      latch_addr(8'd255);
      out_q.push_back(8'h2A);
      cpu_dout = 8'h2A; cpu_out_clk = 1'b1;
      repeat (3) cyc();
      cpu_out_clk = 1'b0;
      cyc();
      dbg_addr = 8'd255;
      @(negedge clk);
      chk("out_latched", out_data, 8'h2A);
      chk("out_count1", out_count, 8'd1);
      chk("out_valid_low", out_valid, 1'b0);
      chk("mem255_after_out", dbg_data, 8'h77);
      wr(8'h2A);
      @(negedge clk);
      chk("mem255_wr_ignored", dbg_data, 8'h77);
      outp(8'h55);
      @(negedge clk);
      chk("out_count2", out_count, 8'd2);
      for (int i = 0; i < 254; i++) outp(8'(i));
      @(negedge clk);
      chk("out_count_wrap", out_count, 8'd0);
      chk("out_last", out_data, 8'hFD);

      // loader blocked while running, then 1-cycle write when held
      load_addr = 8'd4; load_data = 8'h55; load_valid = 1'b1;
      @(negedge clk);
      chk("ld_ready_run", load_ready, 1'b0);
      cyc();
      dbg_addr = 8'd4;
      @(negedge clk);
      chk("ld_blocked", dbg_data, 8'h00);
      run = 1'b0;
      @(negedge clk);
      chk("ld_ready_held", load_ready, 1'b1);
      cyc();
      load_valid = 1'b0;
      @(negedge clk);
      chk("ld_written", dbg_data, 8'h55);

      // run=0: no bus drive, no phantom edges when run rises with strobes held
      cpu_oe_n = 1'b0;
      @(negedge clk);
      chk("held_doe", mem_doe, 1'b0);
      chk("held_dout", mem_dout, 8'h00);
      cpu_oe_n = 1'b1;
      cpu_dout = 8'd2; cpu_latch = 1'b1; cpu_we_n = 1'b0;
      cyc(); cyc();
      run = 1'b1;
      cyc(); cyc();
      cpu_latch = 1'b0; cpu_we_n = 1'b1;
      cyc();
      rd(8'h77);
      dbg_addr = 8'd2;
      @(negedge clk);
      chk("no_phantom_wr", dbg_data, 8'd3);

      // simultaneous latch rise and we fall: write goes to old address
      latch_addr(8'd0);
      cpu_dout = 8'd1; cpu_latch = 1'b1; cpu_we_n = 1'b0;
      cyc();
      cpu_latch = 1'b0; cpu_we_n = 1'b1;
      cyc();
      dbg_addr = 8'd0;
      @(negedge clk);
      chk("simul_old_addr", dbg_data, 8'd1);
      rd(8'd11);

      // contention
      latch_addr(8'd2);
      rd_q.push_back(8'd3);
      cpu_dout = 8'h99; cpu_oe_n = 1'b0; cpu_we_n = 1'b0;
      cyc();
      cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
      dbg_addr = 8'd2;
      @(negedge clk);
      chk("bus_err_set", bus_err, 1'b1);
      chk("contention_no_wr", dbg_data, 8'd3);
      repeat (3) cyc();
      @(negedge clk);
      chk("bus_err_sticky", bus_err, 1'b1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("bus_err_cleared", bus_err, 1'b0);

      // reset mid-access
      latch_addr(8'd10);
      reset = 1'b1; cpu_dout = 8'h66; cpu_we_n = 1'b0;
      cyc();
      reset = 1'b0; cpu_we_n = 1'b1;
      dbg_addr = 8'd10;
      @(negedge clk);
      chk("rst_no_wr", dbg_data, 8'd5);
      wr(8'h44);
      dbg_addr = 8'd0;
      @(negedge clk);
      chk("post_rst_wr_mem0", dbg_data, 8'h44);
      dbg_addr = 8'd10;
      @(negedge clk);
      chk("post_rst_mem10", dbg_data, 8'd5);
      cyc();
      rd(8'h44);

      cyc();
      @(negedge clk);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("out_q_drained", out_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
